// File: rtl/moore_seq_ctrl.sv
// Sequencer that resets a 6-state Moore machine, then feeds it a serial bit pattern.
// It counts how many post-step machine states match a target code.
module moore_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [15:0] pattern,
  input  logic [4:0] len,
  input  logic [2:0] target,
  input  logic [2:0] fsm_state,
  output logic       fsm_in,
  output logic       fsm_rst_n,
  output logic       busy,
  output logic       done,
  output logic [4:0] hit_cnt,
  output logic [4:0] first_hit
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] LAST = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_pattern;
  logic [2:0]  r_target;
  logic [4:0]  r_len;
  logic [4:0]  r_k;
  logic [4:0]  r_hit_cnt;
  logic [4:0]  r_first_hit;

  logic [4:0]  w_eff_len;
  logic        w_cmp;
  logic        w_match;

  assign w_eff_len = (len > 5'd16) ? 5'd16 : len;

  // r_k equals the number of inputs already applied, so it doubles as the step number.
  assign w_cmp   = ((r_state == RUN) && (r_k != 5'd0)) || (r_state == LAST);
  assign w_match = w_cmp && (fsm_state == r_target);

  // NOTE: rst_n is sampled only at the clock edge (synchronous reset), so it is
  // not in the sensitivity list and it overrides every other branch below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_target    <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_hit_cnt   <= '0;
      r_first_hit <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, regardless of statement order.
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pattern   <= pattern;
            r_target    <= target;
            r_len       <= w_eff_len;
            r_k         <= '0;
            r_hit_cnt   <= '0;
            r_first_hit <= '0;
            r_state     <= CLR;
          end
        end
        CLR: begin
          if (abort) begin
            r_hit_cnt   <= '0;
            r_first_hit <= '0;
            r_state     <= IDLE;
          end else begin
            r_state <= (r_len == 5'd0) ? DONE : RUN;
          end
        end
        RUN, LAST: begin
          if (abort) begin
            r_hit_cnt   <= '0;
            r_first_hit <= '0;
            r_state     <= IDLE;
          end else begin
            if (w_match) begin
              if (r_hit_cnt != 5'd16) r_hit_cnt <= r_hit_cnt + 5'd1;
              if (r_first_hit == 5'd0) r_first_hit <= r_k;
            end
            if (r_state == LAST) begin
              r_state <= DONE;
            end else begin
              r_k <= r_k + 5'd1;
              if (r_k == r_len - 5'd1) r_state <= LAST;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign fsm_in    = (r_state == RUN) ? r_pattern[r_k[3:0]] : 1'b0;
  assign fsm_rst_n = (r_state != CLR);
  assign busy      = (r_state == CLR) || (r_state == RUN) || (r_state == LAST);
  assign done      = (r_state == DONE);
  assign hit_cnt   = r_hit_cnt;
  assign first_hit = r_first_hit;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl; the bench itself plays the controlled
// 6-state Moore machine (synchronous reset to state 0).
module tb_moore_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [2:0]  target = '0;
  logic [2:0]  fsm_state;
  logic        fsm_in;
  logic        fsm_rst_n;
  logic        busy;
  logic        done;
  logic [4:0]  hit_cnt;
  logic [4:0]  first_hit;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  moore_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .len       (len),
    .target    (target),
    .fsm_state (fsm_state),
    .fsm_in    (fsm_in),
    .fsm_rst_n (fsm_rst_n),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt),
    .first_hit (first_hit)
  );

  // Controlled machine: 0 -0->1 -1->2; 1 -0->4 -1->5; 2 -0->1 -1->3;
  // 3 -0->4 -1->0; 4 -0->4 -1->5; 5 -0->0 -1->2.
  logic [2:0] m_state = 3'd0;
  assign fsm_state = m_state;

  function automatic logic [2:0] m_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    m_next = b ? 3'd2 : 3'd1;
      3'd1:    m_next = b ? 3'd5 : 3'd4;
      3'd2:    m_next = b ? 3'd3 : 3'd1;
      3'd3:    m_next = b ? 3'd0 : 3'd4;
      3'd4:    m_next = b ? 3'd5 : 3'd4;
      3'd5:    m_next = b ? 3'd2 : 3'd0;
      default: m_next = 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!fsm_rst_n) m_state <= 3'd0;
    else            m_state <= m_next(m_state, fsm_in);
  end

  // Cycle 0 is the negedge where start is raised; lat is the cycle where done is seen.
  task automatic do_run(input logic [15:0] p, input logic [4:0] l, input logic [2:0] t,
                        output int lat, output int nbusy, output int nrst, output int ndone);
    pattern = p; len = l; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; nbusy = 0; nrst = 0; ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) nbusy++;
      if (!fsm_rst_n) nrst++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && c == lat + 1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, fsm_in, fsm_rst_n} !== 4'b0001) $display("FAIL reset_ctl: got %b want 0001", {busy, done, fsm_in, fsm_rst_n});
    else n_pass++;
    n_total++;
    if ({hit_cnt, first_hit} !== 10'd0) $display("FAIL reset_res: got hit=%0d first=%0d want 0/0", hit_cnt, first_hit);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int lat, nb, nr, nd;
    do_run(16'h0007, 5'd3, 3'd3, lat, nb, nr, nd);
    n_total++;
    if (lat !== 6) $display("FAIL ones_latency: got %0d want 6", lat); else n_pass++;
    n_total++;
    if (hit_cnt !== 5'd1 || first_hit !== 5'd2) $display("FAIL ones_result: got hit=%0d first=%0d want 1/2", hit_cnt, first_hit);
    else n_pass++;
    n_total++;
    if (nd !== 1) $display("FAIL ones_done_width: got %0d want 1", nd); else n_pass++;
  endtask

  task automatic test_zeros();
    int lat, nb, nr, nd;
    do_run(16'h0000, 5'd4, 3'd4, lat, nb, nr, nd);
    n_total++;
    if (hit_cnt !== 5'd3 || first_hit !== 5'd2) $display("FAIL zeros_result: got hit=%0d first=%0d want 3/2", hit_cnt, first_hit);
    else n_pass++;
    n_total++;
    if (nb !== 6) $display("FAIL zeros_busy: got %0d want 6", nb); else n_pass++;
    n_total++;
    if (lat !== 7) $display("FAIL zeros_latency: got %0d want 7", lat); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (hit_cnt !== 5'd3 || first_hit !== 5'd2) $display("FAIL zeros_hold: got hit=%0d first=%0d want 3/2", hit_cnt, first_hit);
    else n_pass++;
  endtask

  task automatic test_two();
    int lat, nb, nr, nd;
    do_run(16'h0002, 5'd2, 3'd5, lat, nb, nr, nd);
    n_total++;
    if (hit_cnt !== 5'd1 || first_hit !== 5'd2) $display("FAIL two_result: got hit=%0d first=%0d want 1/2", hit_cnt, first_hit);
    else n_pass++;
    n_total++;
    if (nr !== 1) $display("FAIL two_rst_low: got %0d want 1", nr); else n_pass++;
    n_total++;
    if (lat !== 5) $display("FAIL two_latency: got %0d want 5", lat); else n_pass++;
  endtask

  task automatic test_len_bounds();
    int lat, nb, nr, nd;
    do_run(16'hFFFF, 5'd0, 3'd0, lat, nb, nr, nd);
    n_total++;
    if (lat !== 2) $display("FAIL len0_latency: got %0d want 2", lat); else n_pass++;
    n_total++;
    if (hit_cnt !== 5'd0 || first_hit !== 5'd0 || nb !== 1) $display("FAIL len0_result: got hit=%0d first=%0d busy=%0d want 0/0/1", hit_cnt, first_hit, nb);
    else n_pass++;
    do_run(16'h0000, 5'd20, 3'd4, lat, nb, nr, nd);
    n_total++;
    if (lat !== 19 || nb !== 18) $display("FAIL len20_timing: got lat=%0d busy=%0d want 19/18", lat, nb);
    else n_pass++;
    n_total++;
    if (hit_cnt !== 5'd15 || first_hit !== 5'd2) $display("FAIL len20_result: got hit=%0d first=%0d want 15/2", hit_cnt, first_hit);
    else n_pass++;
  endtask

  // Aborts the pattern-0/len-4/target-4 run during cycle cyc (3 = RUN k=1, 6 = LAST).
  task automatic test_abort_at(input int cyc, input logic [4:0] pre_hits);
    int nd;
    pattern = 16'h0000; len = 5'd4; target = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < cyc; c++) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || hit_cnt !== pre_hits) $display("FAIL abort%0d_pre: got busy=%b hit=%0d want 1/%0d", cyc, busy, hit_cnt, pre_hits);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 5'd0 || first_hit !== 5'd0)
      $display("FAIL abort%0d_post: got busy=%b done=%b hit=%0d first=%0d want 0/0/0/0", cyc, busy, done, hit_cnt, first_hit);
    else n_pass++;
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      @(negedge clk);
    end
    n_total++;
    if (nd !== 0) $display("FAIL abort%0d_no_done: got %0d want 0", cyc, nd); else n_pass++;
  endtask

  task automatic test_after_abort();
    int lat, nb, nr, nd;
    do_run(16'h0000, 5'd4, 3'd4, lat, nb, nr, nd);
    n_total++;
    if (lat !== 7 || hit_cnt !== 5'd3 || first_hit !== 5'd2)
      $display("FAIL rerun: got lat=%0d hit=%0d first=%0d want 7/3/2", lat, hit_cnt, first_hit);
    else n_pass++;
  endtask

  // Start held high: runs begin at cycles 1 and 7, so CLR appears twice in 12 cycles.
  task automatic test_start_held();
    int nd, nr;
    pattern = 16'h0002; len = 5'd2; target = 3'd5; start = 1'b1;
    nd = 0; nr = 0;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      if (done) nd++;
      if (!fsm_rst_n) nr++;
      @(negedge clk);
    end
    start = 1'b0;
    n_total++;
    if (nd !== 2 || nr !== 2) $display("FAIL start_held: got done=%0d clr=%0d want 2/2", nd, nr);
    else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nd;
    pattern = 16'h0000; len = 5'd4; target = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, done, fsm_in, fsm_rst_n} !== 4'b0001 || hit_cnt !== 5'd0 || first_hit !== 5'd0)
      $display("FAIL reset_mid: got ctl=%b hit=%0d first=%0d want 0001/0/0", {busy, done, fsm_in, fsm_rst_n}, hit_cnt, first_hit);
    else n_pass++;
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      @(negedge clk);
    end
    n_total++;
    if (nd !== 0) $display("FAIL reset_mid_no_done: got %0d want 0", nd); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ones();
    test_zeros();
    test_two();
    test_len_bounds();
    test_abort_at(3, 5'd0);
    test_abort_at(6, 5'd2);
    test_after_abort();
    test_start_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
